// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side handshake unit sitting directly downstream of ctrl_unit.
// It takes a one-cycle execute pulse, runs one read or write on a req/ack bus,
// and reports completion back with a one-cycle data_ready pulse. Wait states
// from the slave are tolerated. A bus timeout turns a dead slave into an error
// completion, so the CPU cannot hang.
//
// Ports:
//   I_clk, I_reset_n      clock (rising edge), asynchronous active-low reset
//   I_execute             request strobe, one cycle, honoured only when idle
//   I_write/I_addr/I_data transaction descriptor, sampled with I_execute
//   O_mem_ready           idle and able to accept I_execute
//   O_data_ready          one-cycle completion pulse (reads and writes)
//   O_data                last read result (all ones after a read timeout)
//   O_error               one-cycle pulse with O_data_ready on timeout
//   O_bus_req/we/addr/wdata  bus request; we/addr/wdata qualified by O_bus_req
//   I_bus_ack/I_bus_rdata    slave completion and read data (same cycle)
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready; waiting for I_execute
//   ST_REQ  | O_bus_req asserted; waiting for ack or timeout
//   ST_DONE | one-cycle completion; O_data_ready (and maybe O_error) high

module mem_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,
  input  logic                  I_execute,
  input  logic                  I_write,
  input  logic [ADDR_WIDTH-1:0] I_addr,
  input  logic [DATA_WIDTH-1:0] I_data,
  output logic                  O_mem_ready,
  output logic                  O_data_ready,
  output logic [DATA_WIDTH-1:0] O_data,
  output logic                  O_error,
  output logic                  O_bus_req,
  output logic                  O_bus_we,
  output logic [ADDR_WIDTH-1:0] O_bus_addr,
  output logic [DATA_WIDTH-1:0] O_bus_wdata,
  input  logic                  I_bus_ack,
  input  logic [DATA_WIDTH-1:0] I_bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal count of the wait counter. The counter is cleared when the
  // request is accepted, so reaching TIMEOUT-1 means the request has been on
  // the bus for exactly TIMEOUT cycles.
  localparam int              TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [7:0]      TO_TC    = 8'(TO_LAST);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  state_t     state;
  logic [7:0] wait_cnt;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      O_mem_ready  <= 1'b1;
      O_data_ready <= 1'b0;
      O_error      <= 1'b0;
      O_data       <= '0;
      O_bus_req    <= 1'b0;
      O_bus_we     <= 1'b0;
      O_bus_addr   <= '0;
      O_bus_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_execute) begin
            O_bus_we    <= I_write;
            O_bus_addr  <= I_addr;
            O_bus_wdata <= I_data;
            O_bus_req   <= 1'b1;
            O_mem_ready <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Ack takes priority over the timeout on the same edge.
          if (I_bus_ack) begin
            O_bus_req    <= 1'b0;
            O_bus_we     <= 1'b0;
            O_data_ready <= 1'b1;
            // O_bus_we still holds the direction of this transaction here.
            if (!O_bus_we) begin
              O_data <= I_bus_rdata;
            end
            state <= ST_DONE;
          end else if (TO_EN && (wait_cnt == TO_TC)) begin
            O_bus_req    <= 1'b0;
            O_bus_we     <= 1'b0;
            O_data_ready <= 1'b1;
            O_error      <= 1'b1;
            if (!O_bus_we) begin
              O_data <= '1;
            end
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          O_data_ready <= 1'b0;
          O_error      <= 1'b0;
          O_mem_ready  <= 1'b1;
          state        <= ST_IDLE;
        end

        default: begin
          O_bus_req    <= 1'b0;
          O_bus_we     <= 1'b0;
          O_data_ready <= 1'b0;
          O_error      <= 1'b0;
          O_mem_ready  <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl, built with TIMEOUT = 4. Completions are checked by a
// scoreboard monitor; each scenario task also checks bus timing inline.
module tb_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        execute;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_ready;
  logic        data_ready;
  logic [15:0] data;
  logic        error;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_data;

  mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
    .I_clk       (clk),
    .I_reset_n   (reset_n),
    .I_execute   (execute),
    .I_write     (write),
    .I_addr      (addr),
    .I_data      (wdata),
    .O_mem_ready (mem_ready),
    .O_data_ready(data_ready),
    .O_data      (data),
    .O_error     (error),
    .O_bus_req   (bus_req),
    .O_bus_we    (bus_we),
    .O_bus_addr  (bus_addr),
    .O_bus_wdata (bus_wdata),
    .I_bus_ack   (bus_ack),
    .I_bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every completion pulse must match a pending entry.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: data_ready=1 with no pending transaction");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (data !== e.data) begin
            fails++;
            $display("FAIL sb_data: got %h expected %h", data, e.data);
          end
          tests++;
          if (error !== e.err) begin
            fails++;
            $display("FAIL sb_error: got %b expected %b", error, e.err);
          end
        end
      end else if (error !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL error_alone: error=%b without data_ready", error);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Pulse I_execute; returns just after the accepting edge k.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    while (!mem_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("issue_mem_ready", {15'd0, mem_ready}, 16'd1);
    execute = 1'b1;
    write   = w;
    addr    = a;
    wdata   = d;
    cyc();
    execute = 1'b0;
    addr    = 16'hDEAD;
    wdata   = 16'hDEAD;
    write   = ~w;
    chk("accept_bus_req", {15'd0, bus_req}, 16'd1);
    chk("accept_mem_ready", {15'd0, mem_ready}, 16'd0);
    chk("accept_bus_we", {15'd0, bus_we}, {15'd0, w});
    chk("accept_bus_addr", bus_addr, a);
    if (w) chk("accept_bus_wdata", bus_wdata, d);
  endtask

  // Slave: hold off nwait cycles, then ack. Checks the bus stays stable.
  task automatic serve(input int nwait, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] rd);
    exp_t e;
    for (int i = 0; i < nwait; i++) begin
      chk("wait_bus_req", {15'd0, bus_req}, 16'd1);
      chk("wait_bus_we", {15'd0, bus_we}, {15'd0, w});
      chk("wait_bus_addr", bus_addr, a);
      if (w) chk("wait_bus_wdata", bus_wdata, d);
      cyc();
    end
    chk("pre_ack_bus_req", {15'd0, bus_req}, 16'd1);
    if (!w) last_data = rd;
    e.data = last_data;
    e.err  = 1'b0;
    sb.push_back(e);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    cyc();
    bus_ack   = 1'b0;
    bus_rdata = 16'h0F0F;
    chk("ack_bus_req", {15'd0, bus_req}, 16'd0);
    chk("ack_data_ready", {15'd0, data_ready}, 16'd1);
    chk("ack_error", {15'd0, error}, 16'd0);
    chk("ack_data", data, last_data);
  endtask

  task automatic finish_txn();
    cyc();
    chk("done_mem_ready", {15'd0, mem_ready}, 16'd1);
    chk("done_data_ready", {15'd0, data_ready}, 16'd0);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    execute   = 1'b0;
    write     = 1'b0;
    addr      = '0;
    wdata     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    last_data = '0;
    #23;
    chk("rst_mem_ready", {15'd0, mem_ready}, 16'd1);
    reset_n = 1'b1;
    cyc();
    chk("rst_data_ready", {15'd0, data_ready}, 16'd0);
    chk("rst_error", {15'd0, error}, 16'd0);
    chk("rst_bus_req", {15'd0, bus_req}, 16'd0);
    chk("rst_bus_we", {15'd0, bus_we}, 16'd0);
    chk("rst_data", data, 16'd0);
    chk("rst_bus_addr", bus_addr, 16'd0);
    chk("rst_bus_wdata", bus_wdata, 16'd0);
  endtask

  task automatic test_zero_wait_read();
    issue(1'b0, 16'h0040, 16'h0000);
    serve(0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
    finish_txn();
  endtask

  task automatic test_wait_write();
    // Three wait states: ack lands on the timeout edge and must still win.
    issue(1'b1, 16'h1234, 16'hA5A5);
    serve(3, 1'b1, 16'h1234, 16'hA5A5, 16'h7777);
    finish_txn();
    chk("write_keeps_data", data, 16'hBEEF);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n = 0;
    e.data = 16'hFFFF;
    e.err  = 1'b1;
    sb.push_back(e);
    last_data = 16'hFFFF;
    issue(1'b0, 16'h0200, 16'h0000);
    while (bus_req && n < 20) begin
      n++;
      cyc();
    end
    chk("timeout_req_cycles", 16'(n), 16'd4);
    chk("timeout_data_ready", {15'd0, data_ready}, 16'd1);
    chk("timeout_error", {15'd0, error}, 16'd1);
    chk("timeout_data", data, 16'hFFFF);
    cyc();
    cyc();
    bus_ack   = 1'b1;
    bus_rdata = 16'h1111;
    cyc();
    bus_ack = 1'b0;
    chk("late_ack_bus_req", {15'd0, bus_req}, 16'd0);
    chk("late_ack_data", data, 16'hFFFF);
    chk("late_ack_mem_ready", {15'd0, mem_ready}, 16'd1);
  endtask

  task automatic test_busy();
    exp_t e;
    issue(1'b0, 16'h0300, 16'h0000);
    execute = 1'b1;
    write   = 1'b1;
    addr    = 16'h0999;
    wdata   = 16'h5555;
    cyc();
    execute = 1'b0;
    chk("busy_req_addr", bus_addr, 16'h0300);
    chk("busy_req_we", {15'd0, bus_we}, 16'd0);
    last_data = 16'hC0DE;
    e.data = 16'hC0DE;
    e.err  = 1'b0;
    sb.push_back(e);
    bus_ack   = 1'b1;
    bus_rdata = 16'hC0DE;
    cyc();
    bus_ack = 1'b0;
    chk("busy_done_ready", {15'd0, data_ready}, 16'd1);
    execute = 1'b1;
    addr    = 16'h0AAA;
    cyc();
    execute = 1'b0;
    chk("busy_done_no_req", {15'd0, bus_req}, 16'd0);
    chk("busy_done_addr", bus_addr, 16'h0300);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("busy_idle_no_req", {15'd0, bus_req}, 16'd0);
    end
  endtask

  task automatic test_simultaneous();
    issue(1'b0, 16'h0410, 16'h0000);
    serve(3, 1'b0, 16'h0410, 16'h0000, 16'h1357);
    finish_txn();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 16'h0500, 16'h0000);
    serve(0, 1'b0, 16'h0500, 16'h0000, 16'h2468);
    finish_txn();
    // First cycle with mem_ready = 1: must be accepted immediately.
    issue(1'b1, 16'h0502, 16'h9ABC);
    serve(1, 1'b1, 16'h0502, 16'h9ABC, 16'h0000);
    finish_txn();
    chk("b2b_data", data, 16'h2468);
  endtask

  task automatic test_mid_reset();
    issue(1'b0, 16'h0600, 16'h0000);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_bus_req", {15'd0, bus_req}, 16'd0);
    chk("midrst_mem_ready", {15'd0, mem_ready}, 16'd1);
    chk("midrst_data", data, 16'd0);
    chk("midrst_bus_addr", bus_addr, 16'd0);
    last_data = 16'h0000;
    cyc();
    cyc();
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_no_ready", {15'd0, data_ready}, 16'd0);
    end
    issue(1'b0, 16'h0604, 16'h0000);
    serve(1, 1'b0, 16'h0604, 16'h0000, 16'h5A5A);
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_busy();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    cyc();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
